ysyx_23060061_axil_master: RTL and testbench
============================================

# ysyx_23060061_axil_master

AXI-Lite initiator bridging the core's single-request memory port (IFU/LSU side) onto the AXI-Lite bus served by the SRAM responder. Accepts one read or write request at a time, drives the AR/R or AW/W/B channels with registered valid/ready outputs, and returns read data or write completion to the core as a one-cycle response pulse. Only one transaction is outstanding at a time; there is no ID, burst or reordering support.

## Interface
- ADDR_LO, 32'h8000_0000, lowest legal address (inclusive)
- ADDR_HI, 32'h87ff_ffff, highest legal address (inclusive)

- clk  input  1  single clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  core request present
- req_ready  output  1  bridge can accept request (high only in IDLE)
- req_wen  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_wstrb  input  4  byte strobes for write
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  read data (valid with resp_valid on reads; 0 on writes)
- resp_err  output  1  1 = SLVERR/DECERR from bus or local range fault
- araddr  output  32, arvalid  output  1, arready  input  1
- rdata  input  32, rresp  input  2, rvalid  input  1, rready  output  1
- awaddr  output  32, awvalid  output  1, awready  input  1
- wdata  output  32, wstrb  output  4, wvalid  output  1, wready  input  1
- bresp  input  2, bvalid  input  1, bready  output  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: req_ready=1. On req_valid at clk edge: latch addr/wdata/wstrb/wen.
  - addr outside [ADDR_LO, ADDR_HI]: -> RESP with resp_err=1, resp_rdata=0; no bus activity.
  - read: arvalid<=1, araddr<=req_addr, -> RD_ADDR.
  - write: awvalid<=1, wvalid<=1 (same edge), awaddr/wdata/wstrb loaded, -> WR_REQ.
- RD_ADDR: on arvalid&&arready: arvalid<=0, rready<=1, -> RD_DATA.
- RD_DATA: on rvalid&&rready: capture rdata into resp_rdata, resp_err<=(rresp!=0), rready<=0, -> RESP.
- WR_REQ: AW and W tracked independently; awvalid drops on its own handshake, wvalid on its own; when both done (same or different edges): bready<=1, -> WR_RESP.
- WR_RESP: on bvalid&&bready: resp_err<=(bresp!=0), resp_rdata<=0, bready<=0, -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. Core must sample it; no backpressure.
- Address/data/strobe outputs held stable while corresponding valid is high (AXI rule); valids never deasserted before handshake.
- rresp/bresp values 2'b10 and 2'b11 both map to resp_err=1; 2'b01 (EXOKAY) treated as error as well.

## Timing
- Reset: state=IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err = 0; resp_rdata, araddr, awaddr, wdata = 0; wstrb=0. req_ready=1 in the first cycle after reset deasserts.
- All bus and response outputs are registered; req_ready is decoded from state only (no input-to-output combinational path).
- Read vs zero-wait responder (arready=1, rvalid one cycle after AR): accept edge E0, AR handshake E1, rvalid high after E2, R handshake E3, resp_valid high in cycle after E3, req_ready high after E4.
- Write vs responder with awready=wready=1: accept E0, AW+W handshake E1, bvalid after E2, B handshake E3, resp_valid after E3.
- Range fault: resp_valid in cycle immediately after accept edge.
- Reset mid-transaction: all valids/readies drop at that edge, transaction abandoned, no resp_valid issued; responder must be reset in the same cycle.
- req_valid during non-IDLE states ignored (req_ready=0); request must be held by core.

## Test plan
- Read 0x8000_0010 with responder returning 0xDEAD_BEEF, rresp=0 -> single arvalid pulse with araddr=0x8000_0010, resp_valid one cycle, resp_rdata=0xDEAD_BEEF, resp_err=0.
- Write 0x8000_0020, wdata=0x1234_5678, wstrb=4'b0011 -> awvalid and wvalid rise on same edge with those values; after bvalid, resp_valid=1, resp_err=0, resp_rdata=0.
- Write with awready held low 3 cycles while wready=1 -> wvalid drops after W handshake, awvalid stays high with stable awaddr until awready, bready only after both handshakes.
- Read 0x0000_0000 (out of range) -> no arvalid ever, resp_valid next cycle with resp_err=1.
- Read with rvalid delayed 5 cycles, rresp=2'b10 -> rready held high, resp_err=1 on completion.
- rst asserted while arvalid=1 awaiting arready -> arvalid=0 next cycle, state IDLE, no resp_valid; following read completes normally.

Source files
------------

// File: rtl/ysyx_23060061_axil_master_if.sv
// Signal bundle for the AXI-Lite master: core request/response port plus
// the AR/R/AW/W/B channels toward the SRAM responder.
interface ysyx_23060061_axil_master_if;
    // core request / response side
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    // AXI-Lite read channels
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    // AXI-Lite write channels
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    // the bridge itself
    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    // the surroundings: core plus bus responder
    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060061_axil_master.sv
// AXI-Lite initiator: turns one core request at a time into an AR/R or
// AW/W/B exchange and answers the core with a single-cycle response pulse.
// Every bus and response output comes straight from a flop.
module ysyx_23060061_axil_master #(
    parameter logic [31:0] ADDR_LO = 32'h8000_0000,
    parameter logic [31:0] ADDR_HI = 32'h87ff_ffff
) (
    input  logic clk,
    input  logic rst,
    ysyx_23060061_axil_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic        rready_q, rready_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bready_q, bready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        addr_ok;
    logic        aw_done;
    logic        w_done;

    assign addr_ok = (bus.req_addr >= ADDR_LO) && (bus.req_addr <= ADDR_HI);

    // Next-state and registered-output logic; AW and W retire independently
    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        bready_d     = bready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        aw_done      = !awvalid_q || bus.awready;
        w_done       = !wvalid_q || bus.wready;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!addr_ok) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                        state_d      = RESP;
                    end else if (bus.req_wen) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = bus.req_addr;
                        wdata_d   = bus.req_wdata;
                        wstrb_d   = bus.req_wstrb;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = bus.req_addr;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arvalid_q && bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready_q && bus.rvalid) begin
                    resp_rdata_d = bus.rdata;
                    resp_err_d   = (bus.rresp != 2'b00);
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WR_REQ: begin
                if (awvalid_q && bus.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && bus.wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready_q && bus.bvalid) begin
                    resp_err_d   = (bus.bresp != 2'b00);
                    resp_rdata_d = 32'h0;
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            arvalid_q    <= 1'b0;
            araddr_q     <= 32'h0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= 32'h0;
            wvalid_q     <= 1'b0;
            wdata_q      <= 32'h0;
            wstrb_q      <= 4'h0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.araddr     = araddr_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.rready     = rready_q;
    assign bus.awaddr     = awaddr_q;
    assign bus.awvalid    = awvalid_q;
    assign bus.wdata      = wdata_q;
    assign bus.wstrb      = wstrb_q;
    assign bus.wvalid     = wvalid_q;
    assign bus.bready     = bready_q;

endmodule

// File: tb/tb_ysyx_23060061_axil_master.sv
// Bench for the AXI-Lite master: a configurable-latency responder model on
// the bus side, a scoreboard of expected core responses, and protocol checks.
module tb_ysyx_23060061_axil_master;

    localparam logic [31:0] ADDR_LO = 32'h8000_0000;
    localparam logic [31:0] ADDR_HI = 32'h87ff_ffff;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    ysyx_23060061_axil_master_if bus ();

    ysyx_23060061_axil_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // responder drive registers
    logic        arready_r = 1'b0;
    logic        rvalid_r  = 1'b0;
    logic [31:0] rdata_r   = 32'h0;
    logic [1:0]  rresp_r   = 2'b00;
    logic        awready_r = 1'b0;
    logic        wready_r  = 1'b0;
    logic        bvalid_r  = 1'b0;
    logic [1:0]  bresp_r   = 2'b00;

    assign bus.arready = arready_r;
    assign bus.rvalid  = rvalid_r;
    assign bus.rdata   = rdata_r;
    assign bus.rresp   = rresp_r;
    assign bus.awready = awready_r;
    assign bus.wready  = wready_r;
    assign bus.bvalid  = bvalid_r;
    assign bus.bresp   = bresp_r;

    // responder configuration, set by the stimulus process
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] rdata_cfg = 32'h0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_wstrb = 4'h0;

    // responder bookkeeping
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    int ar_seen = 0, aw_seen = 0;
    bit r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0, wr_both = 0;
    bit hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;
    bit p_ar = 0, p_aw = 0, p_w = 0;

    // scoreboard and monitor state
    exp_t sb[$];
    int   resp_count = 0;
    int   accept_cyc = 0;
    bit   prev_resp  = 0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Responder: reacts at negedges to handshakes completed at the prior posedge
    always @(negedge clk) begin
        if (rst) begin
            arready_r = 0; rvalid_r = 0; awready_r = 0; wready_r = 0; bvalid_r = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; wr_both = 0;
            hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
            p_ar = 0; p_aw = 0; p_w = 0;
        end else begin
            if (hs_ar) begin
                r_pend = 1; r_cnt = 0;
                checkOutput("arvalid_drop", bus.arvalid, 1'b0);
                checkOutput("rready_after_ar", bus.rready, 1'b1);
            end else if (p_ar) begin
                checkOutput("arvalid_hold", bus.arvalid, 1'b1);
            end
            if (hs_r) begin
                rvalid_r = 0;
                checkOutput("rready_drop", bus.rready, 1'b0);
            end
            if (hs_aw) begin
                aw_got = 1;
                checkOutput("awvalid_drop", bus.awvalid, 1'b0);
            end else if (p_aw) begin
                checkOutput("awvalid_hold", bus.awvalid, 1'b1);
            end
            if (hs_w) begin
                w_got = 1;
                checkOutput("wvalid_drop", bus.wvalid, 1'b0);
            end else if (p_w) begin
                checkOutput("wvalid_hold", bus.wvalid, 1'b1);
            end
            if (hs_b) begin
                bvalid_r = 0; wr_both = 0;
                checkOutput("bready_drop", bus.bready, 1'b0);
            end
            if (aw_got && w_got) begin
                wr_both = 1; b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0;
            end
            if (bus.bready) checkOutput("bready_before_both", wr_both, 1'b1);

            if (bus.arvalid) begin
                ar_seen++;
                checkOutput("araddr", bus.araddr, exp_addr);
            end
            if (bus.awvalid) begin
                aw_seen++;
                checkOutput("awaddr", bus.awaddr, exp_addr);
            end
            if (bus.wvalid) begin
                checkOutput("wdata", bus.wdata, exp_wdata);
                checkOutput("wstrb", bus.wstrb, exp_wstrb);
            end

            if (bus.arvalid) begin
                if (ar_cnt >= ar_delay) arready_r = 1;
                else begin arready_r = 0; ar_cnt++; end
            end else begin arready_r = 0; ar_cnt = 0; end
            if (bus.awvalid) begin
                if (aw_cnt >= aw_delay) awready_r = 1;
                else begin awready_r = 0; aw_cnt++; end
            end else begin awready_r = 0; aw_cnt = 0; end
            if (bus.wvalid) begin
                if (w_cnt >= w_delay) wready_r = 1;
                else begin wready_r = 0; w_cnt++; end
            end else begin wready_r = 0; w_cnt = 0; end
            if (r_pend) begin
                if (r_cnt > r_delay) begin
                    rvalid_r = 1; rdata_r = rdata_cfg; rresp_r = rresp_cfg; r_pend = 0;
                end else r_cnt++;
            end
            if (b_pend) begin
                if (b_cnt > b_delay) begin
                    bvalid_r = 1; bresp_r = bresp_cfg; b_pend = 0;
                end else b_cnt++;
            end

            hs_ar = bus.arvalid && arready_r;
            hs_r  = rvalid_r && bus.rready;
            hs_aw = bus.awvalid && awready_r;
            hs_w  = bus.wvalid && wready_r;
            hs_b  = bvalid_r && bus.bready;
            p_ar  = bus.arvalid;
            p_aw  = bus.awvalid;
            p_w   = bus.wvalid;
        end
    end

    // Monitor: pops the scoreboard on every response pulse
    always @(negedge clk) begin
        if (!rst && bus.resp_valid) begin
            exp_t e;
            checkOutput("resp_pulse_width", prev_resp, 1'b0);
            checkOutput("req_ready_in_resp", bus.req_ready, 1'b0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                checkOutput("resp_rdata", bus.resp_rdata, e.rdata);
                checkOutput("resp_err", bus.resp_err, e.err);
                if (e.lat >= 0) checkOutput("resp_latency", cyc - accept_cyc, e.lat);
            end
            resp_count++;
        end
        prev_resp = !rst && bus.resp_valid;
    end

    // Drives one request, predicts its response, optionally waits for it
    task automatic applyStimulus(input logic wen, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input int lat, input bit wait_done);
        exp_t e;
        bit   rdy;
        int   start;
        bit   in_range;
        in_range = (addr >= ADDR_LO) && (addr <= ADDR_HI);
        if (!in_range)  begin e.rdata = 32'h0;     e.err = 1'b1; end
        else if (wen)   begin e.rdata = 32'h0;     e.err = (bresp_cfg != 2'b00); end
        else            begin e.rdata = rdata_cfg; e.err = (rresp_cfg != 2'b00); end
        e.lat = lat;
        sb.push_back(e);
        exp_addr  = addr;
        exp_wdata = wdata;
        exp_wstrb = strb;
        start = resp_count;
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        rdy = 0;
        for (int n = 0; n < 20 && !rdy; n++) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
        end
        #1;
        accept_cyc = cyc;
        bus.req_valid = 1'b0;
        if (!rdy) checkOutput("accept_timeout", 1'b0, 1'b1);
        if (wait_done) begin
            for (int n = 0; n < 80 && resp_count == start; n++) @(negedge clk);
            if (resp_count == start) begin
                checkOutput("resp_timeout", 1'b0, 1'b1);
                sb.delete();
            end
            @(posedge clk); #1;
            @(negedge clk);
            checkOutput("req_ready_after_resp", bus.req_ready, 1'b1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int ar_before, aw_before;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_wstrb = 4'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("rst_req_ready", bus.req_ready, 1'b1);
        checkOutput("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                                   bus.bready, bus.resp_valid, bus.resp_err}, 7'h0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst_araddr", bus.araddr, 32'h0);
        checkOutput("rst_awaddr", bus.awaddr, 32'h0);
        checkOutput("rst_wdata", bus.wdata, 32'h0);
        checkOutput("rst_wstrb", bus.wstrb, 4'h0);
        @(posedge clk); #1;

        $display("[TB] zero-wait read");
        rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
        applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, 3, 1);

        $display("[TB] zero-wait write");
        bresp_cfg = 2'b00;
        applyStimulus(1'b1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 3, 1);

        $display("[TB] write with awready held off");
        aw_delay = 3;
        applyStimulus(1'b1, 32'h8000_0040, 32'hCAFE_F00D, 4'b1100, -1, 1);
        aw_delay = 0;

        $display("[TB] write with wready held off");
        w_delay = 2;
        applyStimulus(1'b1, 32'h8000_0044, 32'h0BAD_0001, 4'b1111, -1, 1);
        w_delay = 0;

        $display("[TB] out-of-range accesses");
        ar_before = ar_seen; aw_before = aw_seen;
        applyStimulus(1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 1);
        applyStimulus(1'b0, 32'h8800_0000, 32'h0, 4'h0, 0, 1);
        applyStimulus(1'b1, 32'h7fff_fffc, 32'h5555_AAAA, 4'hF, 0, 1);
        checkOutput("no_bus_on_range_fault", {ar_seen - ar_before, aw_seen - aw_before}, 64'h0);

        $display("[TB] boundary addresses");
        rdata_cfg = 32'h1357_9BDF;
        applyStimulus(1'b0, ADDR_HI, 32'h0, 4'h0, 3, 1);
        applyStimulus(1'b1, ADDR_LO, 32'hFFFF_0000, 4'b0001, 3, 1);

        $display("[TB] slow read with SLVERR");
        r_delay = 5; rresp_cfg = 2'b10; rdata_cfg = 32'hA5A5_5A5A;
        applyStimulus(1'b0, 32'h8000_0100, 32'h0, 4'h0, 8, 1);
        r_delay = 0;

        $display("[TB] other error codes");
        rresp_cfg = 2'b11; rdata_cfg = 32'h0000_0042;
        applyStimulus(1'b0, 32'h8000_0104, 32'h0, 4'h0, 3, 1);
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b01; b_delay = 2;
        applyStimulus(1'b1, 32'h8000_0108, 32'h8765_4321, 4'b0110, 5, 1);
        bresp_cfg = 2'b00; b_delay = 0;

        $display("[TB] reset during read address phase");
        ar_delay = 1000;
        applyStimulus(1'b0, 32'h8000_0200, 32'h0, 4'h0, -1, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("abort_arvalid", bus.arvalid, 1'b0);
        checkOutput("abort_req_ready", bus.req_ready, 1'b1);
        checkOutput("abort_resp_valid", bus.resp_valid, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        ar_delay = 0;
        repeat (3) @(posedge clk);
        #1;
        rdata_cfg = 32'h2468_ACE0; rresp_cfg = 2'b00;
        applyStimulus(1'b0, 32'h8000_0300, 32'h0, 4'h0, 3, 1);

        repeat (4) @(posedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
